// File: rtl/pragmatic_8_scheduler.sv
// Essential-bit scheduler for the 8-lane Pragmatic MAC: serializes the nonzero magnitude bits of
// each weight into per-lane first-stage offsets under one shared second-stage base shift.
module pragmatic_8_scheduler #(
  parameter int VEC_LENGTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_data,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] a_data,
  input  logic                                  w_load,
  input  logic                                  w_last,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_out,
  output logic [VEC_LENGTH-1:0][1:0]            shift_1st_sel,
  output logic [VEC_LENGTH-1:0]                 shift_1st_en,
  output logic [VEC_LENGTH-1:0]                 is_neg,
  output logic [2:0]                            shift_2nd_sel,
  output logic                                  shift_2nd_en,
  output logic                                  mac_en,
  output logic                                  mac_load_accum,
  output logic                                  busy,
  output logic                                  res_valid
);

  // Handshake: a vector (w_data, a_data, w_load, w_last) transfers on a cycle where w_valid and
  // w_ready are both high; upstream holds it stable until then and w_valid never depends on w_ready.
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, next_state;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mask, mask_next;
  logic [VEC_LENGTH-1:0][2:0]            low;
  logic [VEC_LENGTH-1:0][3:0]            diff;
  logic [VEC_LENGTH-1:0][1:0]            lane_sel;
  logic [VEC_LENGTH-1:0]                 nz, lane_en;
  logic [2:0]                            base;
  logic                                  accept, issuing, last_issue;
  logic                                  load_q, last_q, first_q;
  logic                                  load_accum_q, drain_q, res_pipe_q, res_valid_q;

  always_comb begin : lane_scan
    base = 3'd7;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      nz[i]  = |mask[i];
      low[i] = 3'd0;
      for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
        if (mask[i][b]) low[i] = 3'(b);
      end
    end
    for (int i = 0; i < VEC_LENGTH; i++) begin
      if (nz[i] && (low[i] < base)) base = low[i];
    end
    if (nz == '0) base = 3'd0;
  end

  // A lane issues its lowest pending bit only if it fits the 4-position window above the base.
  always_comb begin : lane_issue
    mask_next = mask;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      diff[i]     = {1'b0, low[i]} - {1'b0, base};
      lane_en[i]  = nz[i] && (diff[i] <= 4'd3);
      lane_sel[i] = lane_en[i] ? diff[i][1:0] : 2'd0;
      if (lane_en[i]) mask_next[i][low[i]] = 1'b0;
    end
  end

  assign issuing    = (state == ISSUE);
  assign last_issue = issuing && (mask_next == '0);
  assign accept     = w_valid && w_ready;

  always_ff @(posedge clk) begin : state_reg
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin : next_state_logic
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (last_issue) next_state = accept ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin : output_logic
    w_ready        = !reset && ((state == IDLE) || last_issue);
    busy           = issuing;
    shift_1st_en   = issuing ? lane_en : '0;
    shift_1st_sel  = issuing ? lane_sel : '0;
    shift_2nd_sel  = issuing ? base : 3'd0;
    shift_2nd_en   = issuing && (lane_en != '0);
    mac_en         = issuing || drain_q;
    mac_load_accum = load_accum_q;
    res_valid      = res_valid_q;
  end

  // The MAC holds each product in psum for one en cycle, hence the delayed load and the drain.
  always_ff @(posedge clk) begin : datapath
    if (reset) begin
      mask         <= '0;
      act_out      <= '0;
      is_neg       <= '0;
      load_q       <= 1'b0;
      last_q       <= 1'b0;
      first_q      <= 1'b0;
      load_accum_q <= 1'b0;
      drain_q      <= 1'b0;
      res_pipe_q   <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < VEC_LENGTH; i++) begin
          mask[i]   <= w_data[i][DATA_WIDTH-1] ? (~w_data[i] + DATA_WIDTH'(1)) : w_data[i];
          is_neg[i] <= w_data[i][DATA_WIDTH-1];
        end
        act_out <= a_data;
        load_q  <= w_load;
        last_q  <= w_last;
      end else if (issuing) begin
        mask <= mask_next;
      end
      first_q      <= accept;
      load_accum_q <= first_q && load_q;
      drain_q      <= last_issue;
      res_pipe_q   <= last_issue && last_q;
      res_valid_q  <= res_pipe_q;
    end
  end

endmodule

// File: tb/tb_pragmatic_8_scheduler.sv
// Directed bench for pragmatic_8_scheduler: a cycle timeline of expected outputs built from the
// bit-issue rules, plus a functional MAC model that checks every completed dot product.
module tb_pragmatic_8_scheduler;
  localparam int TL = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_valid = 1'b0;
  logic w_load = 1'b0;
  logic w_last = 1'b0;
  logic [7:0][7:0] w_data = '0;
  logic [7:0][7:0] a_data = '0;
  logic w_ready, shift_2nd_en, mac_en, mac_load_accum, busy, res_valid;
  logic [7:0][7:0] act_out;
  logic [7:0][1:0] shift_1st_sel;
  logic [7:0]      shift_1st_en, is_neg;
  logic [2:0]      shift_2nd_sel;

  pragmatic_8_scheduler dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .a_data(a_data), .w_load(w_load), .w_last(w_last),
    .act_out(act_out), .shift_1st_sel(shift_1st_sel), .shift_1st_en(shift_1st_en),
    .is_neg(is_neg), .shift_2nd_sel(shift_2nd_sel), .shift_2nd_en(shift_2nd_en),
    .mac_en(mac_en), .mac_load_accum(mac_load_accum), .busy(busy), .res_valid(res_valid)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected timeline, indexed by cycle number
  logic        e_busy[TL], e_ready[TL], e_mac_en[TL], e_la[TL], e_res[TL], e_s2en[TL], skip[TL];
  logic [2:0]  e_s2sel[TL];
  logic [7:0]  e_s1en[TL], e_neg[TL];
  logic [15:0] e_s1sel[TL];
  logic [63:0] e_act[TL];

  int          free_cyc;
  int          m_n;
  int          m_base[9];
  longint      m_dot, run_sum;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic int lowest(input int v);
    for (int b = 0; b < 8; b++) if (((v >> b) & 1) != 0) return b;
    return 0;
  endfunction

  function automatic void clear_from(input int c0);
    for (int c = c0; c < TL; c++) begin
      e_busy[c] = 0; e_ready[c] = 1; e_mac_en[c] = 0; e_la[c] = 0; e_res[c] = 0;
      e_s2en[c] = 0; e_s2sel[c] = 0; e_s1en[c] = 0; e_s1sel[c] = 0; e_neg[c] = 0; e_act[c] = 0;
    end
  endfunction

  function automatic void model_init();
    clear_from(0);
    for (int c = 0; c < TL; c++) skip[c] = 0;
    skip[0] = 1;
    e_ready[1] = 0;
    e_ready[2] = 0;
    free_cyc = 3;
    run_sum = 0;
  endfunction

  // Accept time, per-cycle issue pattern and completion events for one vector.
  function automatic void model_vector(input logic [63:0] w, input logic [63:0] a,
                                       input logic load, input logic last, input int c,
                                       output int t);
    int mag[8];
    int wi, ai, k, base, p, cy;
    logic [7:0] en, neg;
    logic [15:0] sel;
    bit any;
    t = (c > free_cyc) ? c : free_cyc;
    m_dot = 0;
    for (int i = 0; i < 8; i++) begin
      wi = int'($signed(w[8*i +: 8]));
      ai = int'($signed(a[8*i +: 8]));
      mag[i] = (wi < 0) ? -wi : wi;
      neg[i] = (wi < 0);
      m_dot += longint'(wi) * longint'(ai);
    end
    k = 0;
    do begin
      k++;
      base = 8;
      for (int i = 0; i < 8; i++) if (mag[i] != 0 && lowest(mag[i]) < base) base = lowest(mag[i]);
      if (base == 8) base = 0;
      en = '0;
      sel = '0;
      for (int i = 0; i < 8; i++) begin
        p = lowest(mag[i]);
        if (mag[i] != 0 && p <= base + 3) begin
          en[i] = 1'b1;
          sel[2*i +: 2] = 2'(p - base);
          mag[i] -= (1 << p);
        end
      end
      cy = t + k;
      e_busy[cy] = 1; e_mac_en[cy] = 1; e_ready[cy] = 0;
      e_s2sel[cy] = 3'(base); e_s2en[cy] = |en; e_s1en[cy] = en; e_s1sel[cy] = sel;
      m_base[k] = base;
      any = 0;
      for (int i = 0; i < 8; i++) if (mag[i] != 0) any = 1;
    end while (any);
    e_ready[t+k] = 1;
    e_mac_en[t+k+1] = 1;
    if (load) e_la[t+2] = 1;
    if (last) e_res[t+k+2] = 1;
    for (int c2 = t + 1; c2 < TL; c2++) begin
      e_act[c2] = a;
      e_neg[c2] = neg;
    end
    free_cyc = t + k;
    m_n = k;
    run_sum = load ? m_dot : run_sum + m_dot;
    if (last) begin
      exp_q.push_back(run_sum[31:0]);
      exp_cyc_q.push_back(t + k + 2);
    end
  endfunction

  // Reset held through cycles r..r+h-1 aborts everything in flight.
  function automatic void model_reset(input int r, input int h);
    clear_from(r + 1);
    for (int c = r + 1; c < r + h; c++) e_ready[c] = 0;
    skip[r] = 1;
    free_cyc = r + h;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > r) begin
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input logic [63:0] a, input logic load,
                      input logic last);
    int t;
    model_vector(w, a, load, last, cyc, t);
    w_data = w; a_data = a; w_load = load; w_last = last; w_valid = 1'b1;
    while (cyc <= t) next_cycle();
  endtask

  task automatic idle(input int n);
    w_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  // compare process + functional MAC model
  longint psum_m = 0;
  longint result_m = 0;
  longint prod;
  logic [31:0] exp_sum;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < TL && !skip[cyc]) begin
      chk("w_ready", 64'(w_ready), 64'(e_ready[cyc]));
      chk("busy", 64'(busy), 64'(e_busy[cyc]));
      chk("mac_en", 64'(mac_en), 64'(e_mac_en[cyc]));
      chk("mac_load_accum", 64'(mac_load_accum), 64'(e_la[cyc]));
      chk("res_valid", 64'(res_valid), 64'(e_res[cyc]));
      chk("shift_2nd_en", 64'(shift_2nd_en), 64'(e_s2en[cyc]));
      chk("shift_2nd_sel", 64'(shift_2nd_sel), 64'(e_s2sel[cyc]));
      chk("shift_1st_en", 64'(shift_1st_en), 64'(e_s1en[cyc]));
      chk("shift_1st_sel", 64'(shift_1st_sel), 64'(e_s1sel[cyc]));
      chk("is_neg", 64'(is_neg), 64'(e_neg[cyc]));
      chk("act_out", 64'(act_out), e_act[cyc]);
    end
    if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sum_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_sum = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        chk("dot_sum", 64'(result_m[31:0]), 64'(exp_sum));
      end
    end
    prod = 0;
    for (int i = 0; i < 8; i++) begin
      if (shift_1st_en[i] === 1'b1) begin
        if (is_neg[i] === 1'b1)
          prod -= longint'($signed(act_out[i])) * (longint'(1) << (int'(shift_1st_sel[i]) + int'(shift_2nd_sel)));
        else
          prod += longint'($signed(act_out[i])) * (longint'(1) << (int'(shift_1st_sel[i]) + int'(shift_2nd_sel)));
      end
    end
    if (mac_en === 1'b1) begin
      result_m = ((mac_load_accum === 1'b1) ? 0 : result_m) + psum_m;
      psum_m = prod;
    end
  end

  initial begin
    #(TL * 10);
    $display("FAIL watchdog: cycle %0d reached, limit %0d", cyc, TL);
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    repeat (3) next_cycle();
    reset = 1'b0;

    // all ones, acts 1..8
    send(64'h0101010101010101, 64'h0807060504030201, 1'b1, 1'b1);
    chk("pin_n_ones", 64'(m_n), 64'd1);
    chk("pin_dot_ones", 64'(m_dot), 64'd36);
    idle(4);

    // single lane 0x7F: seven issues, base 0..6
    send(64'h000000000000007F, 64'h0000000000000003, 1'b1, 1'b1);
    chk("pin_n_7f", 64'(m_n), 64'd7);
    chk("pin_base_7f", 64'(m_base[7]), 64'd6);
    chk("pin_dot_7f", 64'(m_dot), 64'd381);
    idle(3);

    // window limit: 1, 8, 16
    send(64'h0000000000100801, 64'h0000000000040302, 1'b1, 1'b1);
    chk("pin_n_window", 64'(m_n), 64'd2);
    chk("pin_base_window", 64'(m_base[2]), 64'd4);
    chk("pin_dot_window", 64'(m_dot), 64'd90);
    idle(3);

    // negative extreme: lane3 = -128, act 5
    send(64'h0000000080000000, 64'h0000000005000000, 1'b1, 1'b1);
    chk("pin_base_neg", 64'(m_base[1]), 64'd7);
    chk("pin_dot_neg", 64'(m_dot[31:0]), 64'h00000000FFFFFD80);
    idle(3);

    // back-to-back: A (N=3, load) then B (N=2, last) with w_valid held
    send(64'h0000000000000015, 64'h0000000000000007, 1'b1, 1'b0);
    chk("pin_n_a", 64'(m_n), 64'd3);
    send(64'h0000000000000300, 64'h000000000000FB00, 1'b0, 1'b1);
    chk("pin_n_b", 64'(m_n), 64'd2);
    chk("pin_sum_ab", 64'(run_sum), 64'd132);
    idle(4);

    // mixed signs and windows
    send(64'hB30240FF070064FD, 64'h37FF0301817FEC0A, 1'b1, 1'b1);
    idle(4);

    // all-zero vector
    send(64'h0, 64'h0807060504030201, 1'b1, 1'b1);
    chk("pin_n_zero", 64'(m_n), 64'd1);
    idle(4);

    // reset in cycle 2 of an N=5 vector
    send(64'h000000000000001F, 64'h0000000000000009, 1'b1, 1'b1);
    chk("pin_n_reset", 64'(m_n), 64'd5);
    w_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    model_reset(cyc, 2);
    repeat (2) next_cycle();
    reset = 1'b0;

    // recovery after reset
    send(64'h0101010101010101, 64'h0807060504030201, 1'b1, 1'b1);
    idle(8);

    chk("sums_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pragmatic_8_scheduler.md
# pragmatic_8_scheduler

Essential-bit scheduler that drives the 8-lane Pragmatic MAC unit.
- Accepts one 8-lane weight vector plus its 8 activations per handshake.
- Recodes each weight to sign-magnitude and serially issues only its nonzero magnitude bits.
- Each cycle generates one common second-stage shift and per-lane first-stage offsets, sign and enables.
- Sequences MAC `en`/`load_accum` around the MAC's internal psum register and flags completed output sums.

## Interface
- `VEC_LENGTH`, 8: lanes; fixed at 8.
- `DATA_WIDTH`, 8: activation/weight width; fixed at 8.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `w_valid`  in  1  upstream vector valid.
- `w_ready`  out  1  scheduler accepts a vector this cycle.
- `w_data`  in  8×8 signed  weights, one per lane.
- `a_data`  in  8×8 signed  activations; the range is [-127,127].
- `w_load`  in  1  vector starts a new sum; the MAC loads `result_prev`.
- `w_last`  in  1  vector ends the current output sum.
- `act_out`  out  8×8 signed  registered activations, held for the whole vector.
- `shift_1st_sel`  out  8×2  per-lane offset above the base.
- `shift_1st_en`  out  8×1  per-lane bit issued this cycle.
- `is_neg`  out  8×1  per-lane weight sign.
- `shift_2nd_sel`  out  3  base bit position.
- `shift_2nd_en`  out  1  at least one lane is enabled.
- `mac_en`  out  1  MAC enable.
- `mac_load_accum`  out  1  MAC load_accum.
- `busy`  out  1  vector in issue.
- `res_valid`  out  1  one-cycle pulse; MAC result is final.

## Operation
- **States:** IDLE, ISSUE.
- **Accept:** on `w_valid && w_ready`, register the following:
  - `act_out`, and `is_neg[i]` = `w_data[i][7]`.
  - Mask `m[i]` = |w_data[i]| as 8-bit unsigned; -128 gives 0x80, so bit 7 is valid.
  - `w_load` and `w_last`.
  - Go to ISSUE.
- **Per ISSUE cycle:** outputs are combinational from the registered masks.
  - `p[i]` = lowest set bit of `m[i]`.
  - `base` = min `p[i]` over lanes with nonzero `m[i]`.
  - Lane i is enabled iff `m[i]`≠0 and `p[i]` ≤ `base`+3. An enabled lane has `shift_1st_sel` = `p[i]`-`base`, and bit `p[i]` is cleared.
  - At most one bit is issued per lane per cycle.
  - `shift_2nd_sel` = `base`; `shift_2nd_en` = OR of the lane enables.
  - Disabled lanes have `shift_1st_en`=0 and `shift_1st_sel`=0.
- **Last issue:** the cycle whose next masks are all zero. Go to ISSUE with new data if a vector is accepted that cycle, else to IDLE.
- **All-zero vector:** exactly one ISSUE cycle, all enables 0, `shift_2nd_sel`=0.
- **Issue count N:** N = max over lanes of the window-limited schedule length. N ≤ 8; N = 8 only when a lane mask is 0xFF.
- **w_ready:** 1 in IDLE, and 1 in the last issue cycle. This gives zero-bubble back-to-back operation.
- **MAC pipeline compensation:** the MAC registers psum one `en` cycle before accumulating.
  - `mac_en`=1 in every ISSUE cycle, plus one drain cycle after the last issue.
  - The drain cycle has all shift enables 0. It overlaps the next vector's first issue when back-to-back.
  - `mac_load_accum`=1 in the cycle after the vector's first issue cycle, iff `w_load`.
  - `res_valid`=1 two cycles after the last issue cycle, iff `w_last`.
- **After reset:** the MAC psum register is undefined, so the first vector after reset must carry `w_load`=1. This requirement belongs to the upstream controller.
- **Sign handling:** the scheduler does not correct -128 activations; the range constraint belongs to upstream.

## Timing
- Accept at edge ending cycle t; first issue in t+1; last issue in t+N.
- `mac_load_accum` in t+2; drain in t+N+1.
- `res_valid` in t+N+2. At that cycle the MAC result equals the full dot product.
- Throughput: one vector per N cycles, with no idle gap when `w_valid` is held.
- **During reset:** state IDLE and masks cleared. Every output is 0, including `w_ready`.
- **Reset mid-vector:** aborts the vector. Pending `mac_load_accum`, drain and `res_valid` are dropped.
- **After reset:** `w_ready`=1 in the first cycle with reset low.
- **w_valid in ISSUE:** ignored except in the last issue cycle. Upstream holds data until `w_ready`.

## Test plan
- **All ones:** weights all +1, acts 1..8, `w_load`=`w_last`=1, `result_prev`=0.
  - N=1, `base`=0, all sel 0, all en 1.
  - `mac_load_accum` at t+2, `res_valid` at t+3.
  - MAC accumulates 36 above the `result_prev` pad.
- **Single lane, many bits:** lane0 weight 0x7F, others 0.
  - 7 issue cycles, `shift_2nd_sel` 0..6, lane0 sel 0, other enables 0.
  - `w_ready` high only in cycle 7.
- **Window limit:** weights lane0=1, lane1=8, lane2=16.
  - Cycle1: `base` 0; lane0 sel0, lane1 sel3.
  - Cycle2: `base` 4; lane2 sel0.
  - N=2.
- **Negative extreme:** lane3 weight -128, act 5.
  - One cycle: `is_neg[3]`=1, `shift_2nd_sel`=7, lane3 sel0.
  - Product -640.
- **Back-to-back:** A (N=3, `w_load`=1, `w_last`=0), then B (N=2, `w_last`=1), `w_valid` held.
  - B accepted in A's cycle 3; no idle cycle.
  - `mac_load_accum` only once, at A's first issue+1.
  - `res_valid` once, 2 cycles after B's last issue.
  - Sum equals A+B.
- **Zero vector and mid-vector reset:**
  - All-zero weights: 1 issue cycle with `shift_2nd_en`=0, then `res_valid`.
  - Assert reset in cycle 2 of an N=5 vector: all outputs 0 next cycle and no `res_valid`; `w_ready`=1 after release.
